// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one trial subtract per clock.
// Quotient/Remainder of Dividend/Divisor after WIDTH iterations, with a
// start/done handshake. A zero divisor finishes on the accepting edge with
// Quotient=all-ones, Remainder=Dividend and div_by_zero set.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN selects two's-complement
// operands. The core works on magnitudes, and the signs are applied on the
// RUN->DONE edge.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;    // partial remainder (always < divisor)
    logic [WIDTH-1:0] quo;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dsr;    // divisor magnitude
    logic [CW-1:0]    cnt;

    // Two's-complement negate, written without a width-growing unary minus
    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Trial subtract: P - {0,D} as P + ~{0,D} + 1; carry-out means no borrow
    logic [WIDTH:0]   p;
    logic [WIDTH+1:0] sum;
    logic             cout;
    logic             diff_top_unused;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign p    = {rem, quo[WIDTH-1]};
    assign sum  = {1'b0, p} + {1'b0, ~{1'b0, dsr}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign cout = sum[WIDTH+1];
    // On a successful subtract T < D fits in WIDTH bits, so T's MSB is always 0
    assign diff_top_unused = sum[WIDTH];
    assign rem_nxt = cout ? sum[WIDTH-1:0] : p[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], cout};

    // Operand magnitudes and final results after sign fix-up
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo;    // operand signs differ
    logic neg_rem;    // dividend was negative

    assign dvd_mag = Dividend[WIDTH-1] ? neg(Dividend) : Dividend;
    assign dvs_mag = Divisor[WIDTH-1]  ? neg(Divisor)  : Divisor;
    // Most-negative / -1 gives magnitude 2^(WIDTH-1), which wraps back to itself
    assign quo_fin = neg_quo ? neg(quo_nxt) : quo_nxt;
    assign rem_fin = neg_rem ? neg(rem_nxt) : rem_nxt;

    // Capture operand signs on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (start && (state != RUN)) begin
            neg_quo <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
            neg_rem <= Dividend[WIDTH-1];
        end
    end
`else
    assign dvd_mag = Dividend;
    assign dvs_mag = Divisor;
    assign quo_fin = quo_nxt;
    assign rem_fin = rem_nxt;
`endif

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (Divisor == '0) begin
                            // No iterations needed: finish on this edge
                            state       <= DONE;
                            done        <= 1'b1;
                            Quotient    <= '1;
                            Remainder   <= Dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            rem   <= '0;
                            quo   <= dvd_mag;
                            dsr   <= dvs_mag;
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    // start is deliberately ignored here
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        Quotient  <= quo_fin;
                        Remainder <= rem_fin;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4). Stimulus pushes the expected
// result of every accepted start; a negedge monitor pops and compares on done.
// Define SEQ_DIVIDER_SIGNED_EN for both bench and RTL to test signed mode.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] Dividend, Divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] Quotient, Remainder;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .Dividend(Dividend), .Divisor(Divisor),
        .busy(busy), .done(done),
        .Quotient(Quotient), .Remainder(Remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc;   // index of the accepting edge
        int           lat;   // expected (done cycle - accepting edge)
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compares each done against the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done && busy) chk("done_busy_overlap", 1, 0);
        if (busy) busy_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("quotient",    int'(Quotient),    int'(e.q));
                chk("remainder",   int'(Remainder),   int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
                chk("latency",     cyc - e.acc + 1,   e.lat);
                chk("busy_cycles", busy_cnt,          e.lat - 1);
            end
            busy_cnt = 0;
        end
    end

    // Drive one start at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input bit push);
        exp_t e;
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        if (push) begin
            e.q = eq; e.r = er; e.dbz = edbz;
            e.acc = cyc + 1;
            e.lat = (b == '0) ? 1 : W + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is visible (checks the current one first)
    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done) return;
            @(negedge clk);
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        issue(a, b, eq, er, edbz, 1'b1);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=expired required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; Dividend = '0; Divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_q",    int'(Quotient), 0);
        chk("reset_r",    int'(Remainder), 0);
        chk("reset_dbz",  int'(div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

`ifndef SEQ_DIVIDER_SIGNED_EN
        // 13/3
        op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        @(negedge clk);
        // divide by zero, then back-to-back 15/1
        op(4'd7, 4'd0, 4'hF, 4'd7, 1'b1);
        op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        @(negedge clk);
        // start during RUN is ignored; restart in DONE cycle accepted
        issue(4'd2, 4'd9, 4'd0, 4'd2, 1'b0, 1'b1);
        Dividend = 4'd9; Divisor = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        op(4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
        @(negedge clk);
        // reset mid-operation: accept edge k, reset sampled at edge k+2
        issue(4'd13, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q",    int'(Quotient), 0);
        chk("abort_r",    int'(Remainder), 0);
        chk("abort_dbz",  int'(div_by_zero), 0);
        repeat (8) @(negedge clk);   // monitor flags any stray done
        op(4'd6, 4'd2, 4'd3, 4'd0, 1'b0);
        @(negedge clk);
        // exhaustive against unsigned model
        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++)
                op(W'(a), W'(b), W'(a / b), W'(a % b), 1'b0);
`else
        op(4'h9, 4'd2, 4'hD, 4'hF, 1'b0);   // -7/2
        op(4'h8, 4'hF, 4'h8, 4'h0, 1'b0);   // -8/-1 wraps
        op(4'd7, 4'hE, 4'hD, 4'd1, 1'b0);   // 7/-2
        op(4'h9, 4'd0, 4'hF, 4'h9, 1'b1);   // -7/0
        op(4'd6, 4'd2, 4'd3, 4'd0, 1'b0);
        @(negedge clk);
        // exhaustive against signed model (int / and % truncate toward zero)
        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++) begin
                int sa, sbv;
                sa  = (a > 7) ? a - 16 : a;
                sbv = (b > 7) ? b - 16 : b;
                op(W'(a), W'(b), W'(sa / sbv), W'(sa % sbv), 1'b0);
            end
`endif
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
